// File: rtl/spi_crypto_master_mc_if.sv
// Bus bundle for spi_crypto_master_mc: host-side request/result signals plus
// the serial link to the NSLAVE crypto slaves. The master modport is the
// view taken by the serial master; the slave modport is the view of whatever
// drives the requests and models the slave side.
interface spi_crypto_master_mc_if #(
    parameter int NK     = 4,
    parameter int NB     = 4,
    parameter int NSLAVE = 2
);
    localparam int KEY_W = 32 * NK;
    localparam int MSG_W = 32 * NB;
    localparam int SEL_W = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;

    // Host request side
    logic              start;
    logic              msg_only;
    logic [SEL_W-1:0]  slave_sel;
    logic [MSG_W-1:0]  from_Real_msg;
    logic [KEY_W-1:0]  from_Real_key;
    logic              busy;
    logic              done;
    logic              sel_err;
    logic              timeout_err;
    logic [MSG_W-1:0]  Sipo_Register;

    // Serial link side
    logic              Miso;
    logic              in_valid;
    logic              out_clk;
    logic [NSLAVE-1:0] cs_n;
    logic              Mosi;
    logic              out_valid;

    modport master (
        input  start, msg_only, slave_sel, from_Real_msg, from_Real_key,
        input  Miso, in_valid,
        output out_clk, cs_n, Mosi, out_valid,
        output busy, done, sel_err, timeout_err, Sipo_Register
    );

    modport slave (
        output start, msg_only, slave_sel, from_Real_msg, from_Real_key,
        output Miso, in_valid,
        input  out_clk, cs_n, Mosi, out_valid,
        input  busy, done, sel_err, timeout_err, Sipo_Register
    );
endinterface

// File: rtl/spi_crypto_master_mc.sv
// spi_crypto_master_mc: multi-channel serial crypto master.
// Shifts {msg,key} (or msg alone) MSB-first on Mosi to the slave chosen by
// slave_sel, then collects an MSG_W-bit result from Miso under in_valid and
// publishes it on Sipo_Register with a one-cycle done pulse.
// Optional receive watchdog: define MISO_TIMEOUT_EN to abort RECV after
// TIMEOUT_CYCLES consecutive cycles without an accepted Miso bit.
module spi_crypto_master_mc #(
    parameter int NK             = 4,
    parameter int NB             = 4,
    parameter int NSLAVE         = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic in_clk,
    input logic rst_n,
    spi_crypto_master_mc_if.master bus
);
    localparam int KEY_W = 32 * NK;
    localparam int MSG_W = 32 * NB;
    localparam int SEL_W = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
    localparam int TOT_W = MSG_W + KEY_W;
    // tx_left holds "bits still to send after the one on Mosi" (max TOT_W-1)
    localparam int TXC_W = $clog2(TOT_W);
    // rx_count holds "bits already accepted" (max MSG_W-1 before DONE)
    localparam int RXC_W = $clog2(MSG_W);
`ifdef MISO_TIMEOUT_EN
    localparam int TOC_W = $clog2(TIMEOUT_CYCLES + 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic [TOT_W-1:0]  tx_shift;
    logic [TXC_W-1:0]  tx_left;
    logic [MSG_W-1:0]  rx_shift;
    logic [RXC_W-1:0]  rx_count;
    logic [NSLAVE-1:0] cs_n_r;
    logic              mosi_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              done_r;
    logic              sel_err_r;
    logic [MSG_W-1:0]  result_r;
`ifdef MISO_TIMEOUT_EN
    logic              timeout_err_r;
    logic [TOC_W-1:0]  idle_count;
`endif

    logic [TOT_W-1:0]  tx_load;
    logic [MSG_W-1:0]  rx_next;

    // Active-low chip-select pattern with only the chosen channel driven low.
    function automatic logic [NSLAVE-1:0] select_mask(input logic [SEL_W-1:0] sel);
        logic [NSLAVE-1:0] mask;
        mask = '1;
        for (int i = 0; i < NSLAVE; i++) begin
            if (int'(sel) == i) mask[i] = 1'b0;
        end
        return mask;
    endfunction

    // A select code is usable only if it names an existing channel.
    function automatic logic select_ok(input logic [SEL_W-1:0] sel);
        return (int'(sel) < NSLAVE);
    endfunction

    // Outgoing frame, left-aligned so the message MSB is always on top.
    always_comb begin
        tx_load = {bus.from_Real_msg, bus.from_Real_key};
        if (bus.msg_only) tx_load = {bus.from_Real_msg, {KEY_W{1'b0}}};
    end

    // Receive word after shifting the current Miso bit in on the LSB side.
    always_comb begin
        rx_next = {rx_shift[MSG_W-2:0], bus.Miso};
    end

    // Transaction FSM; every output is registered here.
    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tx_shift      <= '0;
            tx_left       <= '0;
            rx_shift      <= '0;
            rx_count      <= '0;
            cs_n_r        <= '1;
            mosi_r        <= 1'b0;
            out_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            sel_err_r     <= 1'b0;
            result_r      <= '0;
`ifdef MISO_TIMEOUT_EN
            timeout_err_r <= 1'b0;
            idle_count    <= '0;
`endif
        end else begin
            sel_err_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (select_ok(bus.slave_sel)) begin
                            // First bit goes out straight away; the rest
                            // waits in tx_shift already shifted by one.
                            tx_shift    <= {tx_load[TOT_W-2:0], 1'b0};
                            mosi_r      <= tx_load[TOT_W-1];
                            tx_left     <= bus.msg_only ? TXC_W'(MSG_W - 1)
                                                        : TXC_W'(TOT_W - 1);
                            out_valid_r <= 1'b1;
                            busy_r      <= 1'b1;
                            cs_n_r      <= select_mask(bus.slave_sel);
                            state       <= SEND;
                        end else begin
                            sel_err_r <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (tx_left != '0) begin
                        mosi_r   <= tx_shift[TOT_W-1];
                        tx_shift <= {tx_shift[TOT_W-2:0], 1'b0};
                        tx_left  <= tx_left - 1'b1;
                    end else begin
                        // Last bit was on the wire this cycle; chip select
                        // stays asserted through the receive phase.
                        mosi_r      <= 1'b0;
                        out_valid_r <= 1'b0;
                        rx_count    <= '0;
`ifdef MISO_TIMEOUT_EN
                        idle_count  <= '0;
`endif
                        state       <= RECV;
                    end
                end

                RECV: begin
                    if (bus.in_valid) begin
                        rx_shift <= rx_next;
`ifdef MISO_TIMEOUT_EN
                        idle_count <= '0;
`endif
                        if (rx_count == RXC_W'(MSG_W - 1)) begin
                            result_r <= rx_next;
                            done_r   <= 1'b1;
                            cs_n_r   <= '1;
                            rx_count <= '0;
                            state    <= DONE;
                        end else begin
                            rx_count <= rx_count + 1'b1;
                        end
                    end
`ifdef MISO_TIMEOUT_EN
                    else if (idle_count == TOC_W'(TIMEOUT_CYCLES - 1)) begin
                        // Watchdog: finish without touching the result.
                        done_r        <= 1'b1;
                        timeout_err_r <= 1'b1;
                        cs_n_r        <= '1;
                        idle_count    <= '0;
                        state         <= DONE;
                    end else begin
                        idle_count <= idle_count + 1'b1;
                    end
`endif
                end

                DONE: begin
                    // start is deliberately not looked at here.
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
`ifdef MISO_TIMEOUT_EN
                    timeout_err_r <= 1'b0;
`endif
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_clk       = in_clk;
    assign bus.cs_n          = cs_n_r;
    assign bus.Mosi          = mosi_r;
    assign bus.out_valid     = out_valid_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.sel_err       = sel_err_r;
    assign bus.Sipo_Register = result_r;
`ifdef MISO_TIMEOUT_EN
    assign bus.timeout_err   = timeout_err_r;
`else
    assign bus.timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_crypto_master_mc.sv
// Testbench for spi_crypto_master_mc: directed transactions with a bit-level
// scoreboard for Mosi and a result queue for Sipo_Register.
module tb_spi_crypto_master_mc;
    localparam int NK    = 4;
    localparam int NB    = 4;
    localparam int NSL   = 2;
    localparam int TOUT  = 16;
    localparam int MSG_W = 32 * NB;

    logic in_clk = 1'b0;
    logic rst_n  = 1'b0;
    always #5 in_clk = ~in_clk;

    spi_crypto_master_mc_if #(.NK(NK), .NB(NB), .NSLAVE(NSL)) bus ();
    spi_crypto_master_mc #(.NK(NK), .NB(NB), .NSLAVE(NSL), .TIMEOUT_CYCLES(TOUT)) dut (
        .in_clk(in_clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Three-channel instance so an out-of-range select code is representable.
    spi_crypto_master_mc_if #(.NK(1), .NB(1), .NSLAVE(3)) bus3 ();
    spi_crypto_master_mc #(.NK(1), .NB(1), .NSLAVE(3), .TIMEOUT_CYCLES(TOUT)) dut3 (
        .in_clk(in_clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    int checks = 0;
    int errors = 0;
    bit               exp_bits[$];
    logic [MSG_W-1:0] exp_res[$];
    logic [MSG_W-1:0] last_sipo = '0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic run_txn(input logic sel, input bit mo, input logic [127:0] msg,
                           input logic [127:0] key, input logic [127:0] resp,
                           input int every, input bit stray_start, input bit expect_to);
        int L;
        int nsent;
        int cyc;
        int nbits;
        int last_cyc;
        bit seen;
        bit bad;
        logic [255:0] got;
        logic [255:0] want;
        logic [1:0] cs_exp;
        logic [MSG_W-1:0] res_want;

        L      = mo ? 128 : 256;
        cs_exp = sel ? 2'b01 : 2'b10;
        chk("idle_busy", 256'(bus.busy), 256'(0));
        for (int i = 0; i < 128; i++) exp_bits.push_back(msg[127-i]);
        if (!mo) for (int i = 0; i < 128; i++) exp_bits.push_back(key[127-i]);
        if (!expect_to) exp_res.push_back(resp);

        bus.slave_sel     = sel;
        bus.msg_only      = mo;
        bus.from_Real_msg = msg;
        bus.from_Real_key = key;
        bus.start         = 1'b1;
        @(negedge in_clk);
        bus.start         = 1'b0;
        bus.from_Real_msg = ~msg;
        bus.from_Real_key = ~key;
        chk("busy_after_start", 256'(bus.busy), 256'(1));

        // SEND: collect every out_valid bit and compare against the scoreboard
        nsent = 0; cyc = 0; bad = 1'b0; got = '0; want = '0;
        while (bus.out_valid === 1'b1 && cyc < 300) begin
            got = {got[254:0], bus.Mosi};
            if (exp_bits.size() > 0) want = {want[254:0], exp_bits.pop_front()};
            else bad = 1'b1;
            if (bus.cs_n !== cs_exp) bad = 1'b1;
            nsent++;
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.Miso      = 1'($urandom_range(0, 1));
            bus.start     = stray_start && (cyc == 5);
            bus.slave_sel = stray_start ? ~sel : sel;
            @(negedge in_clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk("send_len", 256'(nsent), 256'(L));
        chk("send_bits", got, want);
        chk("send_cs", 256'(bad), 256'(0));
        chk("send_sb_empty", 256'(exp_bits.size()), 256'(0));
        exp_bits.delete();
        chk("recv_sipo_hold", 256'(bus.Sipo_Register), 256'(last_sipo));

        // RECV: feed the response bits with the requested in_valid spacing
        cyc = 0; nbits = 0; last_cyc = -1; seen = 1'b0; bad = 1'b0;
        while (!seen && cyc < 600) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (bus.cs_n !== cs_exp || bus.out_valid !== 1'b0 || bus.Mosi !== 1'b0) bad = 1'b1;
                if (every > 0 && nbits < 128 && (cyc % every) == every - 1) begin
                    bus.in_valid = 1'b1;
                    bus.Miso     = resp[127-nbits];
                    nbits++;
                    last_cyc = cyc;
                end else begin
                    bus.in_valid = 1'b0;
                    bus.Miso     = 1'($urandom_range(0, 1));
                end
                @(negedge in_clk);
                cyc++;
            end
        end
        bus.in_valid = 1'b0;
        chk("done_seen", 256'(seen), 256'(1));
        chk("recv_cs", 256'(bad), 256'(0));
        if (expect_to) begin
            chk("timeout_cycle", 256'(cyc), 256'(TOUT));
            chk("timeout_err", 256'(bus.timeout_err), 256'(1));
            chk("timeout_sipo", 256'(bus.Sipo_Register), 256'(last_sipo));
        end else begin
            chk("done_latency", 256'(cyc - last_cyc), 256'(1));
            chk("bits_accepted", 256'(nbits), 256'(128));
            chk("timeout_err_low", 256'(bus.timeout_err), 256'(0));
            res_want = (exp_res.size() > 0) ? exp_res.pop_front() : 'x;
            chk("sipo", 256'(bus.Sipo_Register), 256'(res_want));
            last_sipo = res_want;
        end
        chk("done_cs", 256'(bus.cs_n), 256'(2'b11));
        @(negedge in_clk);
        chk("done_pulse", 256'(bus.done), 256'(0));
        chk("busy_clear", 256'(bus.busy), 256'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL sim_watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int cyc;

        bus.start = 1'b0; bus.msg_only = 1'b0; bus.slave_sel = '0;
        bus.from_Real_msg = '0; bus.from_Real_key = '0;
        bus.Miso = 1'b0; bus.in_valid = 1'b0;
        bus3.start = 1'b0; bus3.msg_only = 1'b0; bus3.slave_sel = '0;
        bus3.from_Real_msg = '0; bus3.from_Real_key = '0;
        bus3.Miso = 1'b0; bus3.in_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge in_clk);
        chk("rst_cs_n", 256'(bus.cs_n), 256'(2'b11));
        chk("rst_mosi_vld", 256'({bus.Mosi, bus.out_valid}), 256'(0));
        chk("rst_busy_done", 256'({bus.busy, bus.done}), 256'(0));
        chk("rst_errs", 256'({bus.sel_err, bus.timeout_err}), 256'(0));
        chk("rst_sipo", 256'(bus.Sipo_Register), 256'(0));
        rst_n = 1'b1;
        @(negedge in_clk);

        // Full message+key transaction on channel 1, continuous in_valid
        run_txn(1'b1, 1'b0, 128'h00112233445566778899aabbccddeeff,
                128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1, 1'b0, 1'b0);

        // Back-to-back message-only on channel 0, with a stray start while busy
        run_txn(1'b0, 1'b1, 128'hdeadbeef_01234567_89abcdef_f0e1d2c3,
                128'hffffffff_ffffffff_ffffffff_ffffffff,
                128'h80000000_00000000_00000000_00000001, 1, 1'b1, 1'b0);

        // Sparse in_valid: one accepted bit every third cycle
        run_txn(1'b1, 1'b0, 128'h0f0f0f0f_a5a5a5a5_5a5a5a5a_f0f0f0f0,
                128'h13579bdf_2468ace0_fedcba98_76543210,
                128'hcafef00d_12345678_9abcdef0_0badc0de, 3, 1'b0, 1'b0);

        // Out-of-range select on the three-channel instance
        bus3.slave_sel = 2'd3;
        bus3.start     = 1'b1;
        @(negedge in_clk);
        bus3.start = 1'b0;
        chk("selerr_pulse", 256'(bus3.sel_err), 256'(1));
        chk("selerr_idle", 256'({bus3.busy, bus3.out_valid}), 256'(0));
        chk("selerr_cs", 256'(bus3.cs_n), 256'(3'b111));
        @(negedge in_clk);
        chk("selerr_once", 256'(bus3.sel_err), 256'(0));
        chk("selerr_cs_after", 256'(bus3.cs_n), 256'(3'b111));

        // Reset asserted while bit 100 of SEND is on the wire
        bus.slave_sel = 1'b1; bus.msg_only = 1'b0;
        bus.from_Real_msg = 128'h11111111_22222222_33333333_44444444;
        bus.from_Real_key = 128'h55555555_66666666_77777777_88888888;
        bus.start = 1'b1;
        @(negedge in_clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.out_valid === 1'b1 && cyc < 100) begin
            @(negedge in_clk);
            cyc++;
        end
        chk("abort_reached", 256'(cyc), 256'(100));
        rst_n = 1'b0;
        #1;
        chk("abort_cs_n", 256'(bus.cs_n), 256'(2'b11));
        chk("abort_mosi_vld", 256'({bus.Mosi, bus.out_valid}), 256'(0));
        chk("abort_busy_done", 256'({bus.busy, bus.done}), 256'(0));
        chk("abort_sipo", 256'(bus.Sipo_Register), 256'(0));
        last_sipo = '0;
        @(negedge in_clk);
        rst_n = 1'b1;
        @(negedge in_clk);
        run_txn(1'b0, 1'b0, 128'h00112233445566778899aabbccddeeff,
                128'h000102030405060708090a0b0c0d0e0f,
                128'h3925841d_02dc09fb_dc118597_196a0b32, 1, 1'b0, 1'b0);

`ifdef MISO_TIMEOUT_EN
        // Watchdog: no in_valid at all after SEND
        run_txn(1'b1, 1'b1, 128'h0badf00d_0badf00d_0badf00d_0badf00d,
                128'h0, 128'h0, 0, 1'b0, 1'b1);
        run_txn(1'b1, 1'b1, 128'h76543210_fedcba98_01234567_89abcdef,
                128'h0, 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c, 1, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
